// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default pointer width, depth, Gray decode and
// the "opposite wrap" compare used by the full flag.
package fifo_pkg;

    localparam int FIFO_N = 9;

    function automatic int fifo_depth(input int n);
        return 1 << (n - 1);
    endfunction

    // Works on a zero-extended 32-bit value so any N up to 32 can use it.
    function automatic logic [31:0] g2b(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
        return b;
    endfunction

    // The write pointer equals this when it is exactly one lap ahead of the reader.
    function automatic logic [31:0] full_cmp(input logic [31:0] g, input int n);
        return g ^ (32'd3 << (n - 2));
    endfunction

endpackage

// File: rtl/b2g.sv
// Binary to Gray code converter.
module b2g #(
    parameter int N = 9
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer/flag controller of the async FIFO: binary and Gray write
// pointer, read-pointer synchroniser, registered full / almost-full / overflow.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int N           = FIFO_N,
    parameter int AF_LEVEL    = fifo_depth(N) - 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         winc,
    input  logic [N-1:0] rptr_gray,
    output logic         wen,
    output logic [N-2:0] waddr,
    output logic [N-1:0] wptr_gray,
    output logic         wfull,
    output logic         wafull,
    output logic         wovf
);
    localparam logic [N:0] AF_LVL = (N+1)'(AF_LEVEL);

    logic [N-1:0] wbin_q, wbin_d;
    logic [N-1:0] wptr_gray_q, wptr_gray_d;
    logic         wfull_q, wfull_d;
    logic         wafull_q, wafull_d;
    logic         wovf_q, wovf_d;
    logic [N-1:0] rq_q [SYNC_STAGES];
    logic [N-1:0] rq_d [SYNC_STAGES];
    logic [N-1:0] rq2, rbin, level;

    // Plain flop chain, nothing combinational between stages.
    for (genvar k = 0; k < SYNC_STAGES; k++) begin : g_sync
        if (k == 0) begin : g_first
            assign rq_d[k] = rptr_gray;
        end else begin : g_next
            assign rq_d[k] = rq_q[k-1];
        end
    end

    assign rq2 = rq_q[SYNC_STAGES-1];
    assign wen = winc & ~wfull_q;

    b2g #(.N(N)) u_b2g (
        .bin  (wbin_d),
        .gray (wptr_gray_d)
    );

    always_comb begin
        wbin_d   = wbin_q + {{(N-1){1'b0}}, wen};
        rbin     = N'(g2b(32'(rq2)));
        level    = wbin_d - rbin;
        wfull_d  = (wptr_gray_d == N'(full_cmp(32'(rq2), N)));
        wafull_d = ({1'b0, level} >= AF_LVL);
        wovf_d   = winc & wfull_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q      <= '0;
            wptr_gray_q <= '0;
            wfull_q     <= 1'b0;
            wafull_q    <= 1'b0;
            wovf_q      <= 1'b0;
            for (int k = 0; k < SYNC_STAGES; k++) rq_q[k] <= '0;
        end else begin
            wbin_q      <= wbin_d;
            wptr_gray_q <= wptr_gray_d;
            wfull_q     <= wfull_d;
            wafull_q    <= wafull_d;
            wovf_q      <= wovf_d;
            for (int k = 0; k < SYNC_STAGES; k++) rq_q[k] <= rq_d[k];
        end
    end

    assign waddr     = wbin_q[N-2:0];
    assign wptr_gray = wptr_gray_q;
    assign wfull     = wfull_q;
    assign wafull    = wafull_q;
    assign wovf      = wovf_q;

endmodule
